// File: rtl/rpc_ctrl_pkg.sv
// Shared types for the RPC DRAM command arbiter: command payload, FSM states, field widths.
package rpc_ctrl_pkg;

  localparam int unsigned DRAM_ALIGN_POS  = 5;
  localparam int unsigned DRAM_ADDR_WIDTH = 20;

  typedef struct packed {
    logic                       is_write;
    logic [DRAM_ALIGN_POS-1:0]  len;
    logic [DRAM_ADDR_WIDTH-1:0] addr;
  } arb_cmd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rpc_cmd_fifo.sv
// Small circular command FIFO; exposes every slot and its valid flag for address compares.
module rpc_cmd_fifo
  import rpc_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  arb_cmd_t             data_i,
  output logic                 ready_o,
  input  logic                 pop_i,
  output arb_cmd_t             head_o,
  output logic                 empty_o,
  output arb_cmd_t [DEPTH-1:0] entries_o,
  output logic     [DEPTH-1:0] entry_valid_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  arb_cmd_t [DEPTH-1:0] mem;
  logic     [DEPTH-1:0] vld;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 push_ok;
  logic                 pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full FIFO refuses pushes even when popping in the same cycle (no bypass).
  assign full    = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign ready_o = !full;
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty_o;

  assign head_o        = mem[rd_ptr];
  assign entries_o     = mem;
  assign entry_valid_o = vld;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem    <= '0;
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_ok) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= ptr_inc(rd_ptr);
      end
      if (push_ok) begin
        mem[wr_ptr] <= data_i;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/rpc_cmd_arbiter.sv
// Read/write command arbiter for the RPC DRAM command port; read-favouring with write-starvation bound.
// Optional read-after-write hazard blocking is enabled by defining RPC_ARB_HAZARD_CHECK_EN.
module rpc_cmd_arbiter
  import rpc_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rd_valid_i,
  input  logic [DRAM_ALIGN_POS-1:0]  rd_len_i,
  input  logic [DRAM_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                       rd_ready_o,
  input  logic                       wr_valid_i,
  input  logic [DRAM_ALIGN_POS-1:0]  wr_len_i,
  input  logic [DRAM_ADDR_WIDTH-1:0] wr_addr_i,
  output logic                       wr_ready_o,
  output logic                       cmd_valid_o,
  output logic                       cmd_is_write_o,
  output logic [DRAM_ALIGN_POS-1:0]  cmd_len_o,
  output logic [DRAM_ADDR_WIDTH-1:0] cmd_addr_o,
  input  logic                       cmd_ready_i,
  output logic                       rd_pending_o,
  output logic                       wr_pending_o
);

  localparam int unsigned CCW = $clog2(MAX_CONSEC + 1);

  arb_state_e state, state_nxt;
  arb_cmd_t   cmd_q;
  logic [CCW-1:0] consec_cnt, consec_nxt;

  arb_cmd_t rd_in, wr_in, rd_head, wr_head;
  logic     rd_empty, wr_empty, rd_ne, wr_ne, any_ne;
  arb_cmd_t [FIFO_DEPTH-1:0] rd_entries, wr_entries;
  logic     [FIFO_DEPTH-1:0] rd_vld, wr_vld;

  logic hazard_c, grant_wr_c, arb_en_c, rd_pop_c, wr_pop_c;

  always_comb begin
    rd_in          = '0;
    rd_in.is_write = 1'b0;
    rd_in.len      = rd_len_i;
    rd_in.addr     = rd_addr_i;
    wr_in          = '0;
    wr_in.is_write = 1'b1;
    wr_in.len      = wr_len_i;
    wr_in.addr     = wr_addr_i;
  end

  rpc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (rd_valid_i),
    .data_i        (rd_in),
    .ready_o       (rd_ready_o),
    .pop_i         (rd_pop_c),
    .head_o        (rd_head),
    .empty_o       (rd_empty),
    .entries_o     (rd_entries),
    .entry_valid_o (rd_vld)
  );

  rpc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (wr_valid_i),
    .data_i        (wr_in),
    .ready_o       (wr_ready_o),
    .pop_i         (wr_pop_c),
    .head_o        (wr_head),
    .empty_o       (wr_empty),
    .entries_o     (wr_entries),
    .entry_valid_o (wr_vld)
  );

  assign rd_ne  = !rd_empty;
  assign wr_ne  = !wr_empty;
  assign any_ne = rd_ne || wr_ne;

`ifdef RPC_ARB_HAZARD_CHECK_EN
  logic unused_fifo_taps;
  assign unused_fifo_taps = ^{rd_entries, rd_vld};

  // Read head must not overtake any queued or still-presented write to the same address.
  always_comb begin
    hazard_c = 1'b0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (wr_vld[i] && (wr_entries[i].addr == rd_head.addr)) hazard_c = 1'b1;
    end
    if (cmd_valid_o && cmd_q.is_write && !cmd_ready_i && (cmd_q.addr == rd_head.addr))
      hazard_c = 1'b1;
  end
`else
  logic unused_fifo_taps;
  assign unused_fifo_taps = ^{rd_entries, rd_vld, wr_entries, wr_vld};
  assign hazard_c = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_ne) state_nxt = ISSUE;
      ISSUE:   if (cmd_ready_i && !any_ne) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration decision, FIFO pops and next consecutive-read count.
  always_comb begin
    arb_en_c   = 1'b0;
    grant_wr_c = 1'b0;
    rd_pop_c   = 1'b0;
    wr_pop_c   = 1'b0;
    consec_nxt = consec_cnt;
    case (state)
      IDLE:    arb_en_c = any_ne;
      ISSUE:   arb_en_c = cmd_ready_i && any_ne;
      default: arb_en_c = 1'b0;
    endcase
    if (!rd_ne)                                 grant_wr_c = 1'b1;
    else if (!wr_ne)                            grant_wr_c = 1'b0;
    else if (hazard_c)                          grant_wr_c = 1'b1;
    else if (consec_cnt == CCW'(MAX_CONSEC))    grant_wr_c = 1'b1;
    else                                        grant_wr_c = 1'b0;
    if (arb_en_c) begin
      rd_pop_c = !grant_wr_c;
      wr_pop_c = grant_wr_c;
      if (grant_wr_c || !wr_ne)                 consec_nxt = '0;
      else if (consec_cnt != CCW'(MAX_CONSEC))  consec_nxt = consec_cnt + CCW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_q      <= '0;
      consec_cnt <= '0;
    end else if (arb_en_c) begin
      cmd_q      <= grant_wr_c ? wr_head : rd_head;
      consec_cnt <= consec_nxt;
    end
  end

  assign cmd_valid_o    = (state == ISSUE);
  assign cmd_is_write_o = cmd_q.is_write;
  assign cmd_len_o      = cmd_q.len;
  assign cmd_addr_o     = cmd_q.addr;
  assign rd_pending_o   = rd_ne;
  assign wr_pending_o   = wr_ne;

endmodule

// File: tb/tb_rpc_cmd_arbiter.sv
// Directed, table-driven bench for rpc_cmd_arbiter plus hand sequences for starvation, hazard and reset.
module tb_rpc_cmd_arbiter;
  import rpc_ctrl_pkg::*;

  localparam int unsigned AL = DRAM_ALIGN_POS;
  localparam int unsigned AW = DRAM_ADDR_WIDTH;
  localparam int NV = 19;

  logic          clk;
  logic          rst;
  logic          rd_valid, wr_valid, cmd_ready;
  logic [AL-1:0] rd_len, wr_len;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_ready, wr_ready, cmd_valid, cmd_is_write, rd_pending, wr_pending;
  logic [AL-1:0] cmd_len;
  logic [AW-1:0] cmd_addr;

  int checks;
  int failures;

  rpc_cmd_arbiter #(.FIFO_DEPTH(2), .MAX_CONSEC(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rd_valid_i     (rd_valid),
    .rd_len_i       (rd_len),
    .rd_addr_i      (rd_addr),
    .rd_ready_o     (rd_ready),
    .wr_valid_i     (wr_valid),
    .wr_len_i       (wr_len),
    .wr_addr_i      (wr_addr),
    .wr_ready_o     (wr_ready),
    .cmd_valid_o    (cmd_valid),
    .cmd_is_write_o (cmd_is_write),
    .cmd_len_o      (cmd_len),
    .cmd_addr_o     (cmd_addr),
    .cmd_ready_i    (cmd_ready),
    .rd_pending_o   (rd_pending),
    .wr_pending_o   (wr_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rv;
    logic [AL-1:0] rl;
    logic [AW-1:0] ra;
    logic          wv;
    logic [AL-1:0] wl;
    logic [AW-1:0] wa;
    logic          cr;
    logic          ev;
    logic          ew;
    logic [AL-1:0] el;
    logic [AW-1:0] ea;
    logic          err;
    logic          ewr;
    logic          epr;
    logic          epw;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(input int rv, input int rl, input int ra,
                              input int wv, input int wl, input int wa, input int cr,
                              input int ev, input int ew, input int el, input int ea,
                              input int err, input int ewr, input int epr, input int epw);
    vec_t v;
    v.rv = 1'(rv);   v.rl = AL'(rl);  v.ra = AW'(ra);
    v.wv = 1'(wv);   v.wl = AL'(wl);  v.wa = AW'(wa);
    v.cr = 1'(cr);
    v.ev = 1'(ev);   v.ew = 1'(ew);   v.el = AL'(el);  v.ea = AW'(ea);
    v.err = 1'(err); v.ewr = 1'(ewr); v.epr = 1'(epr); v.epw = 1'(epw);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_valid = 1'b0; rd_len = '0; rd_addr = '0;
    wr_valid = 1'b0; wr_len = '0; wr_addr = '0;
    cmd_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Collect is_write of up to n presented commands (cmd_ready held 1), bounded by a cycle budget.
  task automatic collect(input int n, input int budget, output logic [15:0] seq, output int got);
    seq = '0;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      tick();
      if (cmd_valid) begin
        seq[got] = cmd_is_write;
        got++;
      end
    end
  endtask

  logic [15:0] seq;
  int          got;
  int          issued;
  logic        hz_first;

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst = 1'b1;
    #2;
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_rd_ready",  32'(rd_ready),  32'd1);
    chk("rst_wr_ready",  32'(wr_ready),  32'd1);
    chk("rst_pending",   32'({rd_pending, wr_pending}), 32'd0);
    chk("rst_cmd_data",  32'({cmd_is_write, cmd_len, cmd_addr}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single read, stalled write with max len/addr, read FIFO fill and back-pressure.
    vt[0]  = mk(1, 3, 'h00100, 0, 0, 0, 1,  0, 0, 0, 0,          1, 1, 1, 0);
    vt[1]  = mk(0, 0, 0,       0, 0, 0, 1,  1, 0, 3, 'h00100,    1, 1, 0, 0);
    vt[2]  = mk(0, 0, 0,       0, 0, 0, 1,  0, 0, 0, 0,          1, 1, 0, 0);
    vt[3]  = mk(0, 0, 0,       1, 31, 'hFFFFF, 0, 0, 0, 0, 0,    1, 1, 0, 1);
    vt[4]  = mk(0, 0, 0,       0, 0, 0, 0,  1, 1, 31, 'hFFFFF,   1, 1, 0, 0);
    vt[5]  = vt[4];
    vt[6]  = vt[4];
    vt[7]  = vt[4];
    vt[8]  = vt[4];
    vt[9]  = mk(0, 0, 0,       0, 0, 0, 1,  0, 0, 0, 0,          1, 1, 0, 0);
    vt[10] = mk(1, 1, 'h00010, 0, 0, 0, 0,  0, 0, 0, 0,          1, 1, 1, 0);
    vt[11] = mk(1, 2, 'h00020, 0, 0, 0, 0,  1, 0, 1, 'h00010,    1, 1, 1, 0);
    vt[12] = mk(1, 4, 'h00030, 0, 0, 0, 0,  1, 0, 1, 'h00010,    0, 1, 1, 0);
    vt[13] = mk(1, 5, 'h00040, 0, 0, 0, 0,  1, 0, 1, 'h00010,    0, 1, 1, 0);
    vt[14] = mk(1, 5, 'h00040, 0, 0, 0, 1,  1, 0, 2, 'h00020,    1, 1, 1, 0);
    vt[15] = mk(1, 5, 'h00040, 0, 0, 0, 0,  1, 0, 2, 'h00020,    0, 1, 1, 0);
    vt[16] = mk(0, 0, 0,       0, 0, 0, 1,  1, 0, 4, 'h00030,    1, 1, 1, 0);
    vt[17] = mk(0, 0, 0,       0, 0, 0, 1,  1, 0, 5, 'h00040,    1, 1, 0, 0);
    vt[18] = mk(0, 0, 0,       0, 0, 0, 1,  0, 0, 0, 0,          1, 1, 0, 0);

    for (int i = 0; i < NV; i++) begin
      rd_valid = vt[i].rv; rd_len = vt[i].rl; rd_addr = vt[i].ra;
      wr_valid = vt[i].wv; wr_len = vt[i].wl; wr_addr = vt[i].wa;
      cmd_ready = vt[i].cr;
      tick();
      chk($sformatf("v%0d_cmd_valid", i), 32'(cmd_valid),  32'(vt[i].ev));
      chk($sformatf("v%0d_rd_ready", i),  32'(rd_ready),   32'(vt[i].err));
      chk($sformatf("v%0d_wr_ready", i),  32'(wr_ready),   32'(vt[i].ewr));
      chk($sformatf("v%0d_rd_pend", i),   32'(rd_pending), 32'(vt[i].epr));
      chk($sformatf("v%0d_wr_pend", i),   32'(wr_pending), 32'(vt[i].epw));
      if (vt[i].ev) begin
        chk($sformatf("v%0d_is_write", i), 32'(cmd_is_write), 32'(vt[i].ew));
        chk($sformatf("v%0d_len", i),      32'(cmd_len),      32'(vt[i].el));
        chk($sformatf("v%0d_addr", i),     32'(cmd_addr),     32'(vt[i].ea));
      end
    end

    // Write starvation bound: both FIFOs kept full, expect R,R,R,R,W,R,R,R,R,W.
    do_reset();
    rd_valid = 1'b1; rd_len = AL'(1); rd_addr = AW'('h00200);
    wr_valid = 1'b1; wr_len = AL'(2); wr_addr = AW'('h00300);
    cmd_ready = 1'b1;
    collect(10, 60, seq, got);
    chk("starve_count", 32'(got), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve_grant%0d", i), 32'(seq[i]), ((i == 4) || (i == 9)) ? 32'd1 : 32'd0);

    // Same-address read and write queued together.
    do_reset();
    rd_valid = 1'b1; rd_len = AL'(1); rd_addr = AW'('h0ABCD);
    wr_valid = 1'b1; wr_len = AL'(2); wr_addr = AW'('h0ABCD);
    cmd_ready = 1'b1;
    tick();
    rd_valid = 1'b0; wr_valid = 1'b0;
    collect(2, 12, seq, got);
`ifdef RPC_ARB_HAZARD_CHECK_EN
    hz_first = 1'b1;
`else
    hz_first = 1'b0;
`endif
    chk("hazard_count",  32'(got),    32'd2);
    chk("hazard_first",  32'(seq[0]), 32'(hz_first));
    chk("hazard_second", 32'(seq[1]), 32'(!hz_first));

    // Different addresses: read goes first regardless of hazard checking.
    do_reset();
    rd_valid = 1'b1; rd_len = AL'(1); rd_addr = AW'('h01234);
    wr_valid = 1'b1; wr_len = AL'(2); wr_addr = AW'('h0ABCD);
    cmd_ready = 1'b1;
    tick();
    rd_valid = 1'b0; wr_valid = 1'b0;
    collect(2, 12, seq, got);
    chk("nohaz_count",  32'(got),    32'd2);
    chk("nohaz_first",  32'(seq[0]), 32'd0);
    chk("nohaz_second", 32'(seq[1]), 32'd1);

    // Reset while a command is presented and two reads are queued.
    do_reset();
    rd_valid = 1'b1; rd_len = AL'(1); rd_addr = AW'('h00500);
    tick();
    rd_addr = AW'('h00600);
    tick();
    rd_addr = AW'('h00700);
    tick();
    idle_inputs();
    chk("prerst_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("prerst_rd_ready",  32'(rd_ready),  32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_cmd_valid", 32'(cmd_valid),  32'd0);
    chk("midrst_rd_pend",   32'(rd_pending), 32'd0);
    chk("midrst_cmd_addr",  32'(cmd_addr),   32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    cmd_ready = 1'b1;
    issued = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cmd_valid) issued++;
    end
    chk("postrst_rd_ready", 32'(rd_ready), 32'd1);
    chk("postrst_wr_ready", 32'(wr_ready), 32'd1);
    chk("postrst_issued",   32'(issued),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
